quad_step_decoder: RTL and testbench
====================================

# quad_step_decoder

Upstream front end for the 8-bit up/down counter. It takes raw quadrature encoder pins (A, B) and an index pin, and synchronises and glitch-filters them. It then decodes the Gray-code phase sequence into single-cycle `up`/`down` step strobes, plus a `load` strobe with a `preset` value on index, which drive the counter's `up`, `down`, `load` and `preset` inputs. Illegal phase jumps are flagged on a sticky error output.

## Interface
Parameters:
- `FILT_LEN`, default 3: consecutive clocks a synchronised input must hold a new level before it is accepted. Legal range 1..15.
- `INIT_CYC`, default `FILT_LEN+3`: clocks after reset release during which all strobes and `err` updates are suppressed.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `clear_n` in 1: reset, asynchronous, active-low.
- `a_in` in 1: encoder phase A, asynchronous.
- `b_in` in 1: encoder phase B, asynchronous.
- `idx_in` in 1: encoder index, asynchronous.
- `enable` in 1: when 0, phase tracking continues but no strobes are issued.
- `mode` in 2: decode resolution. 2'b00 = x1, 2'b01 = x2, 2'b10/2'b11 = x4.
- `idx_en` in 1: allows index to issue `load`.
- `idx_preset` in 8: value presented on `preset` with `load`.
- `err_clr` in 1: clears `err`.
- `up` out 1: one-cycle forward step strobe.
- `down` out 1: one-cycle reverse step strobe.
- `load` out 1: one-cycle index load strobe.
- `preset` out 8: captured `idx_preset`; valid while `load`=1 and held afterwards.
- `err` out 1: sticky illegal-transition flag.

## Operation
- **Synchronisers.** Two-flop synchroniser per pin (`a_in`, `b_in`, `idx_in`). Flops reset to 0.
- **Filter.** One per synchronised signal: a 4-bit counter plus a filtered-level flop.
  - The counter increments on each clock where the synchronised value differs from the filtered level.
  - It clears to 0 on any clock where they are equal.
  - The filtered level toggles, and the counter clears, on the `FILT_LEN`-th consecutive differing clock.
  - A level held for fewer than `FILT_LEN` clocks is discarded.
  - Filtered levels reset to 0.
- **Phase register.** 2-bit register `{A,B}` holds the previous filtered phase; resets to 00. Each clock it loads the current filtered phase.
- **Forward sequence:** 00→10→11→01→00. **Reverse** is the opposite direction.
- **Step qualification:**
  - x4: every legal transition issues a step.
  - x2: only transitions where A changes (00↔10, 11↔01).
  - x1: only 00→10 (up) and 10→00 (down).
- **Illegal transition:** both bits change in one clock. No step is issued, the phase register still updates, and `err` is set.
- **Error clear:** `err_clr` clears `err` on the next edge. If an illegal transition and `err_clr` occur in the same clock, set wins.
- **Index:** a rising edge of filtered index with `idx_en`=1 and `enable`=1 asserts `load` for one clock and registers `preset`<=`idx_preset` on the same edge.
- **Index/step collision:** if an index and a qualified step fall in the same clock, `load` is issued and the step is dropped. This matches the counter's load-over-count priority.
- **Enable:** `enable`=0 suppresses `up`, `down` and `load`. Phase tracking and `err` detection continue, so re-enabling never emits a stale step.
- **Init window:** during the first `INIT_CYC` clocks after `clear_n` rises, the phase register follows the filtered phase silently. `up`, `down`, `load` stay 0 and `err` is not set. This prevents a false error when pins sit at 11 at reset.
- **Mutual exclusion:** `up` and `down` are never both 1. No strobe is asserted for two consecutive clocks from a single transition.

## Timing
- **Reset values:** `up`=0, `down`=0, `load`=0, `preset`=8'h00, `err`=0; all internal flops 0. Reset takes effect immediately on `clear_n` falling, including mid-transition. Any pending filter count is discarded.
- **Latency, pin to strobe:** a pin level first sampled at edge k produces its strobe as a registered output after edge k+`FILT_LEN`+2, i.e. high during the cycle after edge k+`FILT_LEN`+2. That is `FILT_LEN`+3 edges, 6 for the default.
- **Index latency:** identical to step latency.
- **Throughput:** the minimum accepted phase dwell is `FILT_LEN` clocks. At that spacing strobes occur every `FILT_LEN` clocks.
- **Strobe width:** all strobes are exactly one clock wide and registered. There are no combinational paths from inputs to outputs.
- **`err` timing:** `err` rises on the same edge a step would have been issued.

## Test plan
- **Reset and init:** hold `clear_n`=0 with a_in=b_in=1, release, idle 20 clocks → `up`/`down`/`load`/`err` stay 0 throughout.
- **x4 forward:** `mode`=2, `enable`=1, drive 00→10→11→01→00 holding each phase 8 clocks → exactly 4 one-clock `up` pulses, each 6 edges after its pin change, `down`=0.
- **x1 reverse:** `mode`=0, drive 00→01→11→10→00 → exactly one `down` pulse, on the 10→00 step; no `up`.
- **Glitch rejection:** with `FILT_LEN`=3, pulse a_in high for 2 clocks → no strobe, filtered A unchanged. A 3-clock pulse → one `up` followed by one `down`.
- **Illegal and clear:** jump 00→11 in one clock → `err`=1 and no strobe. Assert `err_clr` and an illegal jump in the same clock → `err` stays 1. `err_clr` alone → `err`=0 next edge.
- **Index priority and mid-operation reset:** `idx_preset`=8'hA5, align an index rising edge with a forward step → `load`=1 and `preset`=8'hA5 for one clock, no `up`. Drop `clear_n` mid-sequence → all outputs 0 immediately.

Source files
------------

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronises and glitch-filters A/B/index pins
// and decodes the Gray-code phase into one-cycle up/down/load strobes.
module quad_step_decoder #(
    parameter int FILT_LEN = 3,
    parameter int INIT_CYC = FILT_LEN + 3
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       idx_in,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       idx_en,
    input  logic [7:0] idx_preset,
    input  logic       err_clr,
    output logic       up,
    output logic       down,
    output logic       load,
    output logic [7:0] preset,
    output logic       err
);
    localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);
    localparam int INIT_W = $clog2(INIT_CYC + 2);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC);

    // Position of a phase along the forward sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_pos(input logic [1:0] ph);
        case (ph)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic [2:0]        pins;  // {a, b, idx}
    logic [2:0]        sync_p0;
    logic [2:0]        sync_p1;
    logic [2:0]        filt_p2;
    logic [3:0]        filt_cnt_p2 [3];
    logic [1:0]        ph_p3;
    logic              idx_p3;
    logic [INIT_W-1:0] init_cnt;
    logic              init_done;

    logic [1:0] ph_cur;
    logic [1:0] ph_delta;
    logic       illegal;
    logic       fwd;
    logic       qual;
    logic       live;
    logic       load_nx;
    logic       up_nx;
    logic       down_nx;

    assign pins = {a_in, b_in, idx_in};

    // Stage p0/p1: two-flop synchronisers
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= pins;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: glitch filters, a level must persist FILT_LEN clocks to be accepted
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            filt_p2 <= '0;
            for (int i = 0; i < 3; i++) filt_cnt_p2[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == filt_p2[i]) begin
                    filt_cnt_p2[i] <= '0;
                end else if (filt_cnt_p2[i] == FILT_LAST) begin
                    filt_p2[i]     <= ~filt_p2[i];
                    filt_cnt_p2[i] <= '0;
                end else begin
                    filt_cnt_p2[i] <= filt_cnt_p2[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            init_cnt <= '0;
        end else if (init_cnt != INIT_LAST) begin
            init_cnt <= init_cnt + INIT_W'(1);
        end
    end

    assign init_done = (init_cnt == INIT_LAST);

    always_comb begin
        ph_cur   = filt_p2[2:1];
        ph_delta = ph_cur ^ ph_p3;
        illegal  = (ph_delta == 2'b11);
        fwd      = (gray_pos(ph_cur) == gray_pos(ph_p3) + 2'd1);
        case (mode)
            2'b00:   qual = ((ph_p3 == 2'b00) && (ph_cur == 2'b10)) ||
                            ((ph_p3 == 2'b10) && (ph_cur == 2'b00));
            2'b01:   qual = ph_delta[1] && !illegal;
            default: qual = (ph_delta != 2'b00) && !illegal;
        endcase
        live    = enable && init_done;
        // Index load wins over a coincident step, matching the counter's priority.
        load_nx = live && idx_en && filt_p2[0] && !idx_p3;
        up_nx   = live && qual && fwd && !load_nx;
        down_nx = live && qual && !fwd && !load_nx;
    end

    // Stage p3: phase history and registered strobes
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            ph_p3  <= '0;
            idx_p3 <= 1'b0;
            up     <= 1'b0;
            down   <= 1'b0;
            load   <= 1'b0;
            preset <= '0;
            err    <= 1'b0;
        end else begin
            ph_p3  <= ph_cur;
            idx_p3 <= filt_p2[0];
            up     <= up_nx;
            down   <= down_nx;
            load   <= load_nx;
            if (load_nx) preset <= idx_preset;
            if (illegal && init_done) err <= 1'b1;
            else if (err_clr)         err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus random pin activity,
// every cycle compared against a sample-history reference model.
module tb_quad_step_decoder;
    localparam int FL   = 3;
    localparam int IC   = FL + 3;
    localparam int MAXN = 8192;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic       idx_in = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b10;
    logic       idx_en = 1'b0;
    logic [7:0] idx_preset = 8'h00;
    logic       err_clr = 1'b0;
    logic       up;
    logic       down;
    logic       load;
    logic [7:0] preset;
    logic       err;

    quad_step_decoder #(.FILT_LEN(FL), .INIT_CYC(IC)) dut (
        .clock(clock), .clear_n(clear_n), .a_in(a_in), .b_in(b_in),
        .idx_in(idx_in), .enable(enable), .mode(mode), .idx_en(idx_en),
        .idx_preset(idx_preset), .err_clr(err_clr), .up(up), .down(down),
        .load(load), .preset(preset), .err(err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int n = 0;
    bit pin_h [3][MAXN];
    bit flt_h [3][MAXN];
    logic [11:0] exp_q = '0;
    bit          err_m = 1'b0;
    logic [7:0]  preset_m = 8'h00;
    int ups = 0, downs = 0, loads = 0, last_up_n = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic bit pin_at(input int w, input int m);
        return (m < 1) ? 1'b0 : pin_h[w][m];
    endfunction

    function automatic bit flt_at(input int w, input int m);
        return (m < 1) ? 1'b0 : flt_h[w][m];
    endfunction

    function automatic int seq_pos(input bit [1:0] ph);
        bit [1:0] seq [4];
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        for (int i = 0; i < 4; i++) if (seq[i] == ph) return i;
        return 0;
    endfunction

    // Reference: a filtered level flips when the last FL synchronised samples
    // (pin value two edges earlier) all disagree with it; outputs follow one edge later.
    task automatic model_edge();
        bit [1:0] cur, prev;
        bit fprev, flip, qual, live, ld, upx, dnx;
        int d;
        n++;
        pin_h[0][n] = a_in;
        pin_h[1][n] = b_in;
        pin_h[2][n] = idx_in;
        for (int w = 0; w < 3; w++) begin
            fprev = flt_at(w, n - 1);
            flip = 1'b1;
            for (int j = 0; j < FL; j++) if (pin_at(w, n - 2 - j) == fprev) flip = 1'b0;
            flt_h[w][n] = fprev ^ flip;
        end
        cur  = {flt_at(0, n - 1), flt_at(1, n - 1)};
        prev = {flt_at(0, n - 2), flt_at(1, n - 2)};
        d    = (seq_pos(cur) - seq_pos(prev) + 4) % 4;
        live = (enable === 1'b1) && (n > IC);
        ld   = live && (idx_en === 1'b1) && flt_at(2, n - 1) && !flt_at(2, n - 2);
        case (mode)
            2'b00:   qual = ((prev == 2'b00) && (d == 1)) || ((prev == 2'b10) && (d == 3));
            2'b01:   qual = (cur[1] != prev[1]);
            default: qual = 1'b1;
        endcase
        upx = live && !ld && qual && (d == 1);
        dnx = live && !ld && qual && (d == 3);
        if ((d == 2) && (n > IC)) err_m = 1'b1;
        else if (err_clr === 1'b1) err_m = 1'b0;
        if (ld) preset_m = idx_preset;
        exp_q = {upx, dnx, ld, err_m, preset_m};
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        chk($sformatf("outs@%0d", n), {20'd0, up, down, load, err, preset}, {20'd0, exp_q});
        ups   += int'(up);
        downs += int'(down);
        loads += int'(load);
        if (up) last_up_n = n;
    endtask

    task automatic hold(input bit [1:0] ph, input bit idx, input int cyc);
        a_in   = ph[1];
        b_in   = ph[0];
        idx_in = idx;
        repeat (cyc) tick();
    endtask

    task automatic zero_counts();
        ups = 0; downs = 0; loads = 0;
    endtask

    task automatic do_reset(input bit [1:0] ph);
        clear_n = 1'b0;
        a_in = ph[1];
        b_in = ph[0];
        idx_in = 1'b0;
        #1;
        chk("rst_outs", {20'd0, up, down, load, err, preset}, 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        n = 0;
        err_m = 1'b0;
        preset_m = 8'h00;
        clear_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int chg, p, dwell, r;
        bit [1:0] seq [4];
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};

        // Reset with pins parked at 11, then a quiet init window
        enable = 1'b1; mode = 2'b10; idx_en = 1'b1;
        do_reset(2'b11);
        zero_counts();
        hold(2'b11, 1'b0, 20);
        chk("init_quiet", ups + downs + loads + int'(err), 0);
        hold(2'b01, 1'b0, 8);
        hold(2'b00, 1'b0, 8);

        // x4 forward
        zero_counts();
        chg = n + 1;
        hold(2'b10, 1'b0, 8);
        chk("x4_latency", last_up_n - chg, FL + 2);
        hold(2'b11, 1'b0, 8);
        hold(2'b01, 1'b0, 8);
        hold(2'b00, 1'b0, 8);
        chk("x4_ups", ups, 4);
        chk("x4_downs", downs, 0);

        // x1 reverse
        mode = 2'b00;
        zero_counts();
        hold(2'b01, 1'b0, 8);
        hold(2'b11, 1'b0, 8);
        hold(2'b10, 1'b0, 8);
        hold(2'b00, 1'b0, 8);
        chk("x1_ups", ups, 0);
        chk("x1_downs", downs, 1);

        // Glitch rejection
        mode = 2'b10;
        zero_counts();
        hold(2'b10, 1'b0, 2);
        hold(2'b00, 1'b0, 8);
        chk("glitch_short", ups + downs, 0);
        hold(2'b10, 1'b0, FL);
        hold(2'b00, 1'b0, 8);
        chk("glitch_ups", ups, 1);
        chk("glitch_downs", downs, 1);

        // Illegal jump, clear, set-wins-over-clear
        zero_counts();
        hold(2'b11, 1'b0, 8);
        chk("err_set", err, 1);
        chk("err_nostep", ups + downs, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", err, 0);
        a_in = 1'b0; b_in = 1'b0;
        repeat (FL + 2) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_setwins", err, 1);
        hold(2'b00, 1'b0, 4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr2", err, 0);

        // Index coinciding with a forward step
        idx_preset = 8'hA5;
        zero_counts();
        hold(2'b10, 1'b1, 8);
        chk("idx_loads", loads, 1);
        chk("idx_noup", ups, 0);
        chk("idx_preset", preset, 8'hA5);
        hold(2'b10, 1'b0, 8);
        hold(2'b00, 1'b0, 8);
        chk("idx_held", preset, 8'hA5);

        // Asynchronous reset in the middle of a transition
        hold(2'b11, 1'b0, 8);
        a_in = 1'b0;
        repeat (3) tick();
        @(posedge clock);
        #3;
        clear_n = 1'b0;
        #1;
        chk("async_rst", {20'd0, up, down, load, err, preset}, 32'd0);
        do_reset(2'b00);

        // Random activity
        p = 0;
        hold(seq[p], 1'b0, 10);
        for (int s = 0; s < 260; s++) begin
            r = $urandom_range(0, 15);
            if (r == 0)     p = (p + 2) % 4;
            else if (r < 8) p = (p + 1) % 4;
            else            p = (p + 3) % 4;
            mode       = 2'($urandom_range(0, 3));
            enable     = ($urandom_range(0, 7) != 0);
            idx_en     = 1'($urandom_range(0, 1));
            idx_preset = 8'($urandom);
            a_in       = seq[p][1];
            b_in       = seq[p][0];
            idx_in     = ($urandom_range(0, 3) == 0);
            dwell      = $urandom_range(1, 9);
            repeat (dwell) begin
                err_clr = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        err_clr = 1'b0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
